md_audio_mixer: RTL

- Downstream consumer of the console ASIC's audio outputs.
- Integrates the time-multiplexed YM3438 DAC outputs MOL/MOR over one full FM slot window and samples the PSG level.
- Combines both into saturated 16-bit signed stereo PCM with a one-cycle valid strobe.
- Feeds the board-level audio sink (I2S/PWM encoder or simulation dump); runs entirely in the MCLK domain.

---
 rtl/md_audio_mixer_pkg.sv | 19 +
 rtl/md_audio_mixer_if.sv | 28 ++
 rtl/md_audio_sat.sv | 38 +++
 rtl/md_audio_mixer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/md_audio_mixer_pkg.sv
// Shared audio types and constants for the MD audio mixer.
// Holds FSM states, PCM limits and datapath widths.
package md_audio_mixer_pkg;

    localparam int FM_W  = 9;
    localparam int PCM_W = 16;
    localparam int ACC_W = 15;
    localparam int PSG_W = 16;

    localparam logic [PCM_W-1:0] PCM_MAX = 16'h7fff;
    localparam logic [PCM_W-1:0] PCM_MIN = 16'h8000;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        MIX   = 2'd1,
        EMIT  = 2'd2
    } state_t;

endpackage

// File: rtl/md_audio_mixer_if.sv
// Audio mixer bus: FM/PSG inputs from the console ASIC
// and the PCM stereo sample stream to the audio sink.
interface md_audio_mixer_if;
    import md_audio_mixer_pkg::*;

    logic             FM_PHI_EN;
    logic             FM_SYNC;
    logic [FM_W-1:0]  MOL;
    logic [FM_W-1:0]  MOR;
    logic [PSG_W-1:0] PSG;
    logic             MUTE;
    logic [PCM_W-1:0] AUD_L;
    logic [PCM_W-1:0] AUD_R;
    logic             AUD_VALID;
    logic             CLIP_L;
    logic             CLIP_R;

    modport master (
        output FM_PHI_EN, FM_SYNC, MOL, MOR, PSG, MUTE,
        input  AUD_L, AUD_R, AUD_VALID, CLIP_L, CLIP_R
    );

    modport slave (
        input  FM_PHI_EN, FM_SYNC, MOL, MOR, PSG, MUTE,
        output AUD_L, AUD_R, AUD_VALID, CLIP_L, CLIP_R
    );

endinterface

// File: rtl/md_audio_sat.sv
// One channel of the mixer: scale the FM window sum, add the
// attenuated PSG level and saturate to signed 16-bit PCM.
module md_audio_sat
    import md_audio_mixer_pkg::*;
#(
    parameter int FM_SHIFT  = 2,
    parameter int PSG_SHIFT = 3
) (
    input  logic [ACC_W-1:0] sum,
    input  logic [PSG_W-1:0] psg,
    output logic [PCM_W-1:0] pcm,
    output logic             clip
);

    // Two guard bits keep the scaled sum plus PSG term exact.
    localparam int MIX_W = ACC_W + FM_SHIFT + 2;
    localparam int TOP_W = MIX_W - PCM_W + 1;

    logic [MIX_W-1:0] fm_ext;
    logic [MIX_W-1:0] fm_term;
    logic [MIX_W-1:0] psg_term;
    logic [MIX_W-1:0] mix;

    // Overflow shows up as upper bits that are not a pure sign extension.
    always_comb begin
        fm_ext   = {{(MIX_W-ACC_W){sum[ACC_W-1]}}, sum};
        fm_term  = fm_ext << FM_SHIFT;
        psg_term = MIX_W'(psg >> PSG_SHIFT);
        mix      = fm_term + psg_term;
        clip     = 1'b0;
        pcm      = mix[PCM_W-1:0];
        if (mix[MIX_W-1:PCM_W-1] != {TOP_W{mix[MIX_W-1]}}) begin
            clip = 1'b1;
            pcm  = mix[MIX_W-1] ? PCM_MIN : PCM_MAX;
        end
    end

endmodule

// File: rtl/md_audio_mixer.sv
// Integrates YM3438 MOL/MOR over one FM slot window, mixes in the
// PSG level and emits saturated stereo PCM with a valid strobe.
module md_audio_mixer
    import md_audio_mixer_pkg::*;
#(
    parameter int FM_SLOTS  = 24,
    parameter int FM_SHIFT  = 2,
    parameter int PSG_SHIFT = 3
) (
    input  logic              MCLK,
    input  logic              SRES,
    md_audio_mixer_if.slave   bus
);

    localparam int CNT_W = $clog2(FM_SLOTS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FM_SLOTS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc_l;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] samp_l;
    logic [ACC_W-1:0] samp_r;
    logic [ACC_W-1:0] sum_l;
    logic [ACC_W-1:0] sum_r;
    logic [PSG_W-1:0] psg_q;
    logic [CNT_W-1:0] cnt;
    logic             window_ok;
    logic             syncing;
    logic             closing;
    logic [PCM_W-1:0] sat_l;
    logic [PCM_W-1:0] sat_r;
    logic             sat_cl;
    logic             sat_cr;
    logic [PCM_W-1:0] mix_l;
    logic [PCM_W-1:0] mix_r;
    logic             mix_cl;
    logic             mix_cr;
    logic [PCM_W-1:0] aud_l;
    logic [PCM_W-1:0] aud_r;
    logic             aud_valid;
    logic             clip_l;
    logic             clip_r;

    assign samp_l  = {{(ACC_W-FM_W){bus.MOL[FM_W-1]}}, bus.MOL};
    assign samp_r  = {{(ACC_W-FM_W){bus.MOR[FM_W-1]}}, bus.MOR};
    assign syncing = bus.FM_PHI_EN & bus.FM_SYNC;
    assign closing = bus.FM_PHI_EN & (cnt == LAST) & ~bus.FM_SYNC;

    // FSM state register.
    always_ff @(posedge MCLK or negedge SRES) begin
        if (!SRES) state <= ACCUM;
        else       state <= state_nxt;
    end

    // Next state: a closed window is only mixed once sync was seen.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (closing && window_ok) state_nxt = MIX;
            MIX:     state_nxt = EMIT;
            EMIT:    state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // Slot counter and accumulators; sync restarts the window at slot 0.
    always_ff @(posedge MCLK or negedge SRES) begin
        if (!SRES) begin
            acc_l     <= '0;
            acc_r     <= '0;
            sum_l     <= '0;
            sum_r     <= '0;
            psg_q     <= '0;
            cnt       <= '0;
            window_ok <= 1'b0;
        end else if (syncing) begin
            acc_l     <= samp_l;
            acc_r     <= samp_r;
            cnt       <= CNT_W'(1);
            window_ok <= 1'b1;
        end else if (closing) begin
            sum_l <= acc_l + samp_l;
            sum_r <= acc_r + samp_r;
            psg_q <= bus.PSG;
            acc_l <= '0;
            acc_r <= '0;
            cnt   <= '0;
        end else if (bus.FM_PHI_EN) begin
            acc_l <= acc_l + samp_l;
            acc_r <= acc_r + samp_r;
            cnt   <= cnt + 1'b1;
        end
    end

    md_audio_sat #(
        .FM_SHIFT  (FM_SHIFT),
        .PSG_SHIFT (PSG_SHIFT)
    ) u_sat_l (
        .sum  (sum_l),
        .psg  (psg_q),
        .pcm  (sat_l),
        .clip (sat_cl)
    );

    md_audio_sat #(
        .FM_SHIFT  (FM_SHIFT),
        .PSG_SHIFT (PSG_SHIFT)
    ) u_sat_r (
        .sum  (sum_r),
        .psg  (psg_q),
        .pcm  (sat_r),
        .clip (sat_cr)
    );

    // Capture the saturated mix during the MIX cycle.
    always_ff @(posedge MCLK or negedge SRES) begin
        if (!SRES) begin
            mix_l  <= '0;
            mix_r  <= '0;
            mix_cl <= 1'b0;
            mix_cr <= 1'b0;
        end else if (state == MIX) begin
            mix_l  <= sat_l;
            mix_r  <= sat_r;
            mix_cl <= sat_cl;
            mix_cr <= sat_cr;
        end
    end

    // Output register: samples hold between strobes, clip pulses with valid.
    always_ff @(posedge MCLK or negedge SRES) begin
        if (!SRES) begin
            aud_l     <= '0;
            aud_r     <= '0;
            aud_valid <= 1'b0;
            clip_l    <= 1'b0;
            clip_r    <= 1'b0;
        end else begin
            aud_valid <= 1'b0;
            clip_l    <= 1'b0;
            clip_r    <= 1'b0;
            if (state == EMIT) begin
                aud_l     <= bus.MUTE ? '0 : mix_l;
                aud_r     <= bus.MUTE ? '0 : mix_r;
                aud_valid <= 1'b1;
                clip_l    <= mix_cl;
                clip_r    <= mix_cr;
            end
        end
    end

    assign bus.AUD_L     = aud_l;
    assign bus.AUD_R     = aud_r;
    assign bus.AUD_VALID = aud_valid;
    assign bus.CLIP_L    = clip_l;
    assign bus.CLIP_R    = clip_r;

endmodule
